// File: rtl/dut_or_pkg.sv
// Shared constants for the bit-wide OR peripheral.
// Address map and FIFO depths used by the top and its testbench.
package dut_or_pkg;

    localparam logic [2:0] ADDR_A_STATUS = 3'd0;
    localparam logic [2:0] ADDR_B_STATUS = 3'd1;
    localparam logic [2:0] ADDR_Y_STATUS = 3'd2;
    localparam logic [2:0] ADDR_Y_DATA   = 3'd3;
    localparam logic [2:0] ADDR_A_DATA   = 3'd4;
    localparam logic [2:0] ADDR_B_DATA   = 3'd5;

    localparam int A_DEPTH = 2;
    localparam int B_DEPTH = 2;
    localparam int Y_DEPTH = 1;

endpackage

// File: rtl/dut_or_fifo_unit_fifo.sv
// Single-bit circular FIFO with occupancy-based full/empty.
// Pushes to a full FIFO and pops from an empty one are ignored.
module bit_fifo #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enq,
    input  logic deq,
    input  logic din,
    output logic dout,
    output logic full,
    output logic empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] mem;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             push;
    logic             pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Full/empty use the pre-edge count, so a same-cycle pop never frees room
    assign push  = enq && !full;
    assign pop   = deq && !empty;
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign dout  = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: rtl/dut_or_fifo_unit.sv
// Memory-mapped OR unit: operands pushed into A/B, results popped from Y.
// Top holds address decode, compute enable and the read multiplexer.
module dut_or_fifo_unit
    import dut_or_pkg::*;
(
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [2:0] write_address,
    input  logic       write_data,
    input  logic       write_en,
    output logic       write_rdy,
    input  logic [2:0] read_address,
    input  logic       read_en,
    output logic       read_data,
    output logic       read_rdy
);

    logic a_enq, b_enq, y_deq, fire;
    logic a_dout, b_dout, y_dout;
    logic a_full, b_full, y_full;
    logic a_empty, b_empty, y_empty;

    assign write_rdy = 1'b1;
    assign read_rdy  = 1'b1;

    assign a_enq = write_en && (write_address == ADDR_A_DATA);
    assign b_enq = write_en && (write_address == ADDR_B_DATA);
    assign y_deq = read_en && (read_address == ADDR_Y_DATA);

    // Y has no bypass, so a result can only land when Y is already empty
    assign fire = !a_empty && !b_empty && y_empty;

    bit_fifo #(.DEPTH(A_DEPTH)) u_fifo_a (
        .clk   (CLK),
        .rst_n (RST_N),
        .enq   (a_enq),
        .deq   (fire),
        .din   (write_data),
        .dout  (a_dout),
        .full  (a_full),
        .empty (a_empty)
    );

    bit_fifo #(.DEPTH(B_DEPTH)) u_fifo_b (
        .clk   (CLK),
        .rst_n (RST_N),
        .enq   (b_enq),
        .deq   (fire),
        .din   (write_data),
        .dout  (b_dout),
        .full  (b_full),
        .empty (b_empty)
    );

    bit_fifo #(.DEPTH(Y_DEPTH)) u_fifo_y (
        .clk   (CLK),
        .rst_n (RST_N),
        .enq   (fire),
        .deq   (y_deq),
        .din   (a_dout | b_dout),
        .dout  (y_dout),
        .full  (y_full),
        .empty (y_empty)
    );

    always_comb begin
        read_data = 1'b0;
        unique case (1'b1)
            (read_address == ADDR_A_STATUS): read_data = !a_full;
            (read_address == ADDR_B_STATUS): read_data = !b_full;
            (read_address == ADDR_Y_STATUS): read_data = !y_empty;
            (read_address == ADDR_Y_DATA):   read_data = !y_empty && y_dout;
            default:                         read_data = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_dut_or_fifo_unit.sv
// Testbench for dut_or_fifo_unit: directed vector table, reset sequence,
// and randomized traffic against a queue-based reference model.
module tb_dut_or_fifo_unit;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic [2:0] write_address = '0;
    logic       write_data = 1'b0;
    logic       write_en = 1'b0;
    logic       write_rdy;
    logic [2:0] read_address = '0;
    logic       read_en = 1'b0;
    logic       read_data;
    logic       read_rdy;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic       we;
        logic [2:0] wa;
        logic       wd;
        logic       re;
        logic [2:0] ra;
        logic       exp;
    } vec_t;

    vec_t vq[$];

    bit qa[$];
    bit qb[$];
    bit qy[$];

    dut_or_fifo_unit dut (
        .CLK           (CLK),
        .RST_N         (RST_N),
        .write_address (write_address),
        .write_data    (write_data),
        .write_en      (write_en),
        .write_rdy     (write_rdy),
        .read_address  (read_address),
        .read_en       (read_en),
        .read_data     (read_data),
        .read_rdy      (read_rdy)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic add(input logic we, input logic [2:0] wa, input logic wd,
                       input logic re, input logic [2:0] ra, input logic exp);
        vec_t v;
        v.we = we; v.wa = wa; v.wd = wd;
        v.re = re; v.ra = ra; v.exp = exp;
        vq.push_back(v);
    endtask

    task automatic drive(input logic we, input logic [2:0] wa, input logic wd,
                         input logic re, input logic [2:0] ra);
        @(negedge CLK);
        write_en      = we;
        write_address = wa;
        write_data    = wd;
        read_en       = re;
        read_address  = ra;
    endtask

    function automatic logic model_read(input logic [2:0] ra);
        case (ra)
            3'd0: return qa.size() < 2;
            3'd1: return qb.size() < 2;
            3'd2: return qy.size() != 0;
            3'd3: return (qy.size() != 0) ? qy[0] : 1'b0;
            default: return 1'b0;
        endcase
    endfunction

    initial begin
        bit ab [4][2];
        ab = '{'{0, 0}, '{0, 1}, '{1, 0}, '{1, 1}};

        // reset state reads
        add(0, 0, 0, 0, 0, 1);
        add(0, 0, 0, 0, 1, 1);
        add(0, 0, 0, 0, 2, 0);
        add(0, 0, 0, 0, 3, 0);
        // A=1, B=0, result after one more edge
        add(1, 4, 1, 0, 0, 1);
        add(1, 5, 0, 0, 2, 0);
        add(0, 0, 0, 0, 2, 0);
        add(0, 0, 0, 0, 2, 1);
        add(0, 0, 0, 1, 3, 1);
        add(0, 0, 0, 0, 2, 0);
        // all four combinations
        for (int i = 0; i < 4; i++) begin
            add(1, 4, ab[i][0], 0, 2, 0);
            add(1, 5, ab[i][1], 0, 2, 0);
            add(0, 0, 0, 0, 2, 0);
            add(0, 0, 0, 1, 3, ab[i][0] | ab[i][1]);
        end
        // backpressure on A
        add(1, 4, 1, 0, 0, 1);
        add(1, 4, 0, 0, 0, 1);
        add(1, 4, 1, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0);
        add(1, 5, 0, 0, 0, 0);
        add(1, 5, 0, 0, 0, 0);
        add(0, 0, 0, 1, 3, 1);
        add(0, 0, 0, 0, 2, 0);
        add(0, 0, 0, 0, 2, 1);
        add(0, 0, 0, 1, 3, 0);
        add(0, 0, 0, 0, 2, 0);
        add(0, 0, 0, 0, 0, 1);
        // Y full stalls the second compute
        add(1, 4, 1, 0, 0, 1);
        add(1, 5, 0, 0, 1, 1);
        add(1, 4, 0, 0, 0, 1);
        add(1, 5, 0, 0, 2, 1);
        add(0, 0, 0, 0, 0, 1);
        add(0, 0, 0, 0, 1, 1);
        add(0, 0, 0, 1, 3, 1);
        add(0, 0, 0, 0, 2, 0);
        add(0, 0, 0, 0, 2, 1);
        add(0, 0, 0, 1, 3, 0);
        add(0, 0, 0, 0, 2, 0);
        // unmapped write and reads
        add(1, 6, 1, 1, 4, 0);
        add(1, 7, 1, 1, 5, 0);
        add(1, 0, 1, 1, 6, 0);
        add(1, 3, 1, 1, 7, 0);
        add(0, 0, 0, 0, 0, 1);
        add(0, 0, 0, 0, 1, 1);
        add(0, 0, 0, 0, 2, 0);
        add(0, 0, 0, 0, 3, 0);

        #1;
        check("rdy_w_in_reset", write_rdy, 1'b1);
        check("rdy_r_in_reset", read_rdy, 1'b1);
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;

        foreach (vq[i]) begin
            drive(vq[i].we, vq[i].wa, vq[i].wd, vq[i].re, vq[i].ra);
            #1;
            check($sformatf("vec%0d", i), read_data, vq[i].exp);
        end

        // fill all FIFOs, then reset asynchronously mid-cycle
        drive(1, 4, 1, 0, 0);
        drive(1, 5, 1, 0, 0);
        drive(0, 0, 0, 0, 0);
        drive(1, 4, 1, 0, 0);
        drive(1, 4, 1, 0, 0);
        drive(1, 5, 1, 0, 0);
        drive(0, 0, 0, 0, 2);
        #1;
        check("pre_rst_y", read_data, 1'b1);
        read_address = 3'd0;
        #1;
        check("pre_rst_a_full", read_data, 1'b0);
        RST_N = 1'b0;
        #1;
        for (int a = 0; a < 4; a++) begin
            read_address = 3'(a);
            #1;
            check($sformatf("rst_addr%0d", a), read_data, a < 2);
        end
        check("rdy_w_mid_reset", write_rdy, 1'b1);
        check("rdy_r_mid_reset", read_rdy, 1'b1);
        @(negedge CLK);
        RST_N = 1'b1;

        for (int i = 0; i < 600; i++) begin
            logic       we, wd, re;
            logic [2:0] wa, ra;
            bit         fire, res, pop_y;
            bit         push_a, push_b;
            we = 1'($urandom_range(0, 1));
            wa = 3'($urandom_range(3, 6));
            wd = 1'($urandom_range(0, 1));
            re = 1'($urandom_range(0, 1));
            ra = 3'($urandom_range(0, 7));
            drive(we, wa, wd, re, ra);
            #1;
            check($sformatf("rnd%0d", i), read_data, model_read(ra));
            fire   = qa.size() > 0 && qb.size() > 0 && qy.size() == 0;
            res    = fire ? (qa[0] | qb[0]) : 1'b0;
            pop_y  = re && ra == 3'd3 && qy.size() > 0;
            push_a = we && wa == 3'd4 && qa.size() < 2;
            push_b = we && wa == 3'd5 && qb.size() < 2;
            if (pop_y) void'(qy.pop_front());
            if (fire) begin
                void'(qa.pop_front());
                void'(qb.pop_front());
                qy.push_back(res);
            end
            if (push_a) qa.push_back(wd);
            if (push_b) qb.push_back(wd);
        end

        @(negedge CLK);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
